multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 32-bit MIPS datapath (R-type, addi, lw, sw, beq, j).
//  - One FSM steps the shared ALU, memory, IR and regfile through fetch, decode, execute,
//    memory and writeback, one state per clock.
//  - Memory waits on a ready handshake; a watchdog aborts stuck accesses.
//  - Emits per-cycle datapath controls plus instr_done / illegal / error status pulses.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles in a memory state before abort (1..255)
//  TMO_W        8   width of wait counter; must hold MEM_TIMEOUT
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  asynchronous active-low reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  mem_ready    in   1  memory completes current access this cycle
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load if ALU zero (gated externally)
//  i_or_d       out  1  mem address: 0=PC, 1=ALUOut
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  ir_write     out  1  IR load
//  mem_to_reg   out  1  regfile wdata: 0=ALUOut, 1=MDR
//  reg_dst      out  1  regfile waddr: 0=rt, 1=rd
//  reg_write    out  1  regfile write enable
//  alu_src_a    out  1  0=PC, 1=A
//  alu_src_b    out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op       out  2  00=add, 01=sub, 10=funct-decoded
//  pc_source    out  2  00=ALU, 01=ALUOut, 10=jump target
//  instr_done   out  1  1-cycle pulse in last state of each instruction
//  illegal_op   out  1  1-cycle pulse: unknown opcode seen in DECODE
//  mem_err      out  1  1-cycle pulse: memory watchdog expired
//  state_o      out  4  current state code (debug)
// BEHAVIOUR
//  - Reset (async): state=RST; all outputs 0; wait counter 0.
//  - Output timing: outputs decode combinationally from state. Only pc_write/ir_write in FETCH
//    and the wait-state exits are qualified by mem_ready.
//  - Output default: any output not listed for a state is 0.
//  States, their outputs and next state:
//   RST      -> FETCH unconditionally (one idle cycle after reset release).
//   FETCH    mem_read, i_or_d=0, src_a=0, src_b=01, op=00, pc_src=00;
//            ir_write=pc_write=mem_ready; ready -> DECODE, else stay.
//   DECODE   src_a=0, src_b=11, op=00.
//            Next by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH,
//            001000 -> ADDIEX, 000010 -> JUMP; other -> FETCH with illegal_op.
//   MEMADR   src_a=1, src_b=10, op=00. lw -> MEMRD, sw -> MEMWR.
//   MEMRD    mem_read, i_or_d=1; ready -> MEMWB.
//   MEMWB    reg_dst=0, mem_to_reg=1, reg_write, instr_done -> FETCH.
//   MEMWR    mem_write, i_or_d=1; ready -> FETCH with instr_done.
//   EXEC     src_a=1, src_b=00, op=10 -> RWB.
//   RWB      reg_dst=1, reg_write, instr_done -> FETCH.
//   BRANCH   src_a=1, src_b=00, op=01, pc_write_cond, pc_src=01, instr_done -> FETCH.
//   ADDIEX   src_a=1, src_b=10, op=00 -> ADDIWB.
//   ADDIWB   reg_dst=0, mem_to_reg=0, reg_write, instr_done -> FETCH.
//   JUMP     pc_write, pc_src=10, instr_done -> FETCH.
//  Wait counter (FETCH, MEMRD, MEMWR):
//   - Clears on state entry; increments each cycle without mem_ready.
//   - Watchdog: count==MEM_TIMEOUT with no ready -> mem_err pulse, -> FETCH.
//     No PC/IR/regfile write, no instr_done; the instruction is abandoned and FETCH
//     re-issues the same PC.
//   - Precedence: mem_ready in the timeout cycle wins (normal completion, no mem_err).
//  - Opcode is sampled only in DECODE and MEMADR; changes elsewhere are ignored.
//  - Reset mid-instruction: immediate return to RST; all outputs 0 in the same cycle.
//    No partial writes are issued.
// STRUCTURE
//  - mc_ctrl_pkg: opcode constants, state encoding (4-bit, RST=0), ALUOp, ALUSrcB and
//    PCSource codes.
//  - Sub-module mem_wait_timer: clear/enable/expire counter, parameterised by MEM_TIMEOUT.
//  - Top: state register, next-state logic, output decode.
// TESTING
//  - Reset, then add with mem_ready=1: states RST,FETCH,DECODE,EXEC,RWB; reg_dst=1 and
//    reg_write=1 in RWB; instr_done once.
//  - lw with mem_ready low 3 cycles in MEMRD: MEMRD held 4 cycles; MEMWB has mem_to_reg=1,
//    reg_write=1; total 8 cycles FETCH..MEMWB.
//  - beq and j: BRANCH drives pc_write_cond=1, alu_op=01, pc_source=01; JUMP drives
//    pc_write=1, pc_source=10; each takes 3 cycles.
//  - opcode 6'b111111: illegal_op pulses in DECODE, next state FETCH, no write enables.
//  - Watchdog: sw with mem_ready stuck 0 and MEM_TIMEOUT=15 -> mem_err after 16 MEMWR
//    cycles, then FETCH. Repeat with ready in cycle 16: no mem_err.
//  - rst_n low during MEMWR: mem_write=0 immediately, state_o=0, FETCH one cycle after
//    release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states and
// the datapath mux/ALU control codes.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for memory states; expire flags that MEM_TIMEOUT unanswered
// cycles have already elapsed in the current state.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TMO_W'(1);
        end
    end

    assign expire = (count == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: one state per clock, memory states wait on
// mem_ready and are abandoned by a watchdog when the memory never answers.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state_o
);

    state_t state;
    state_t next_state;
    logic   wait_state;
    logic   expire;
    logic   timeout;
    logic   tmr_clear;
    logic   tmr_enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
        end else begin
            state <= next_state;
        end
    end

    // A completed access always beats the watchdog in the same cycle.
    assign wait_state = is_mem_wait(state);
    assign timeout    = wait_state && expire && !mem_ready;
    assign tmr_enable = wait_state && !mem_ready;
    assign tmr_clear  = !wait_state || (next_state != state) || timeout;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expire (expire)
    );

    always_comb begin
        next_state    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        mem_err       = 1'b0;

        case (state)
            S_RST: next_state = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end else if (timeout) begin
                    mem_err = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end else if (timeout) begin
                    mem_err    = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end else if (timeout) begin
                    mem_err    = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_FUNCT;
                next_state = S_RWB;
            end
            S_RWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_ALUOUT;
                instr_done    = 1'b1;
                next_state    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCS_JUMP;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_RST;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a table of per-cycle vectors plus
// hand-written watchdog and mid-instruction reset sequences.
module tb_multicycle_ctrl;
    import mc_ctrl_pkg::*;

    // Control bundle: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
    // instr_done, illegal_op, mem_err}
    localparam logic [18:0] C_ZERO    = 19'b0000000000_00_00_00_000;
    localparam logic [18:0] C_FETCH_R = 19'b1001010000_01_00_00_000;
    localparam logic [18:0] C_FETCH_W = 19'b0001000000_01_00_00_000;
    localparam logic [18:0] C_FETCH_T = 19'b0001000000_01_00_00_001;
    localparam logic [18:0] C_DEC     = 19'b0000000000_11_00_00_000;
    localparam logic [18:0] C_DEC_ILL = 19'b0000000000_11_00_00_010;
    localparam logic [18:0] C_MADR    = 19'b0000000001_10_00_00_000;
    localparam logic [18:0] C_MRD     = 19'b0011000000_00_00_00_000;
    localparam logic [18:0] C_MWB     = 19'b0000001010_00_00_00_100;
    localparam logic [18:0] C_MWR_W   = 19'b0010100000_00_00_00_000;
    localparam logic [18:0] C_MWR_R   = 19'b0010100000_00_00_00_100;
    localparam logic [18:0] C_MWR_T   = 19'b0010100000_00_00_00_001;
    localparam logic [18:0] C_EXEC    = 19'b0000000001_00_10_00_000;
    localparam logic [18:0] C_RWB     = 19'b0000000110_00_00_00_100;
    localparam logic [18:0] C_BR      = 19'b0100000001_00_01_01_100;
    localparam logic [18:0] C_ADDIWB  = 19'b0000000010_00_00_00_100;
    localparam logic [18:0] C_JMP     = 19'b1000000000_00_00_10_100;

    localparam logic [5:0] O_ADD = 6'b000000;
    localparam logic [5:0] O_LW  = 6'b100011;
    localparam logic [5:0] O_SW  = 6'b101011;
    localparam logic [5:0] O_BEQ = 6'b000100;
    localparam logic [5:0] O_ADI = 6'b001000;
    localparam logic [5:0] O_J   = 6'b000010;
    localparam logic [5:0] O_BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctl;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        instr_done, illegal_op, mem_err;
    logic [3:0]  state_o;
    logic [18:0] ctl;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    multicycle_ctrl #(.MEM_TIMEOUT(15), .TMO_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .mem_err       (mem_err),
        .state_o       (state_o)
    );

    assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, instr_done, illegal_op, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [3:0] st, input logic [18:0] c);
        n_checks++;
        if (state_o !== st) begin
            n_fail++;
            $display("FAIL %s state: got %0d expected %0d", name, state_o, st);
        end
        n_checks++;
        if (ctl !== c) begin
            n_fail++;
            $display("FAIL %s controls: got %b expected %b", name, ctl, c);
        end
    endtask

    task automatic step(input string name, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input logic [18:0] c);
        @(negedge clk);
        opcode    = op;
        mem_ready = rdy;
        #1;
        check(name, st, c);
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [18:0] c);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.ctl = c;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = O_ADD;
        mem_ready = 1'b0;

        add(O_ADD, 1'b0, S_RST,    C_ZERO);
        // add (opcode changed during EXEC must be ignored)
        add(O_ADD, 1'b1, S_FETCH,  C_FETCH_R);
        add(O_ADD, 1'b1, S_DECODE, C_DEC);
        add(O_J,   1'b1, S_EXEC,   C_EXEC);
        add(O_J,   1'b1, S_RWB,    C_RWB);
        // lw with three wait cycles in MEMRD
        add(O_LW,  1'b1, S_FETCH,  C_FETCH_R);
        add(O_LW,  1'b1, S_DECODE, C_DEC);
        add(O_LW,  1'b1, S_MEMADR, C_MADR);
        add(O_LW,  1'b0, S_MEMRD,  C_MRD);
        add(O_LW,  1'b0, S_MEMRD,  C_MRD);
        add(O_LW,  1'b0, S_MEMRD,  C_MRD);
        add(O_LW,  1'b1, S_MEMRD,  C_MRD);
        add(O_LW,  1'b0, S_MEMWB,  C_MWB);
        // beq, j, addi
        add(O_BEQ, 1'b1, S_FETCH,  C_FETCH_R);
        add(O_BEQ, 1'b1, S_DECODE, C_DEC);
        add(O_BEQ, 1'b1, S_BRANCH, C_BR);
        add(O_J,   1'b1, S_FETCH,  C_FETCH_R);
        add(O_J,   1'b1, S_DECODE, C_DEC);
        add(O_J,   1'b1, S_JUMP,   C_JMP);
        add(O_ADI, 1'b1, S_FETCH,  C_FETCH_R);
        add(O_ADI, 1'b1, S_DECODE, C_DEC);
        add(O_ADI, 1'b1, S_ADDIEX, C_MADR);
        add(O_ADI, 1'b1, S_ADDIWB, C_ADDIWB);
        // illegal opcode, then fetch stalls, then a sw completing at once
        add(O_BAD, 1'b1, S_FETCH,  C_FETCH_R);
        add(O_BAD, 1'b1, S_DECODE, C_DEC_ILL);
        add(O_SW,  1'b0, S_FETCH,  C_FETCH_W);
        add(O_SW,  1'b0, S_FETCH,  C_FETCH_W);
        add(O_SW,  1'b1, S_FETCH,  C_FETCH_R);
        add(O_SW,  1'b1, S_DECODE, C_DEC);
        add(O_SW,  1'b1, S_MEMADR, C_MADR);
        add(O_SW,  1'b1, S_MEMWR,  C_MWR_R);

        repeat (2) @(negedge clk);
        #1;
        check("reset_hold", S_RST, C_ZERO);
        @(posedge clk);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].rdy, vecs[i].st, vecs[i].ctl);
        end

        // sw watchdog: sixteen unanswered MEMWR cycles
        step("wd_fetch", O_SW, 1'b1, S_FETCH, C_FETCH_R);
        step("wd_dec", O_SW, 1'b1, S_DECODE, C_DEC);
        step("wd_adr", O_SW, 1'b1, S_MEMADR, C_MADR);
        for (int i = 1; i <= 15; i++) step($sformatf("wd_wait%0d", i), O_SW, 1'b0, S_MEMWR, C_MWR_W);
        step("wd_expire", O_SW, 1'b0, S_MEMWR, C_MWR_T);

        // same access answered in the timeout cycle
        step("wdr_fetch", O_SW, 1'b1, S_FETCH, C_FETCH_R);
        step("wdr_dec", O_SW, 1'b1, S_DECODE, C_DEC);
        step("wdr_adr", O_SW, 1'b1, S_MEMADR, C_MADR);
        for (int i = 1; i <= 15; i++) step($sformatf("wdr_wait%0d", i), O_SW, 1'b0, S_MEMWR, C_MWR_W);
        step("wdr_ready16", O_SW, 1'b1, S_MEMWR, C_MWR_R);

        // fetch watchdog re-issues FETCH with a fresh count
        for (int i = 1; i <= 15; i++) step($sformatf("wdf_wait%0d", i), O_SW, 1'b0, S_FETCH, C_FETCH_W);
        step("wdf_expire", O_SW, 1'b0, S_FETCH, C_FETCH_T);
        step("wdf_refetch", O_SW, 1'b0, S_FETCH, C_FETCH_W);
        step("wdf_ready", O_SW, 1'b1, S_FETCH, C_FETCH_R);

        // reset asserted mid-MEMWR
        step("rm_dec", O_SW, 1'b1, S_DECODE, C_DEC);
        step("rm_adr", O_SW, 1'b0, S_MEMADR, C_MADR);
        step("rm_memwr", O_SW, 1'b0, S_MEMWR, C_MWR_W);
        #2 rst_n = 1'b0;
        #1;
        check("rm_async", S_RST, C_ZERO);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step("rm_idle", O_SW, 1'b1, S_RST, C_ZERO);
        step("rm_fetch", O_SW, 1'b1, S_FETCH, C_FETCH_R);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
